// File: rtl/fpu_arb_pkg.sv
// Shared types and helpers for the FPU arithmetic-unit arbiter.
package fpu_arb_pkg;

    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int FP80_W  = 80;

    localparam logic [FP80_W-1:0] FP80_ZERO = '0;
    localparam logic              OP_MUL    = 1'b0;
    localparam logic              OP_DIV    = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RESP    = 3'd3,
        RELEASE = 3'd4
    } chan_state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First asserted req at or after ptr, searching modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && req[j[IDX_W-1:0]]) begin
                r.vld = 1'b1;
                r.idx = j[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_arb_channel.sv
// One round-robin arbitration channel in front of a shared external FP unit.
module fpu_arb_channel
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = 80,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0][W-1:0]   a_i,
    input  logic [NUM_REQ-1:0][W-1:0]   b_i,
    input  logic [NUM_REQ-1:0]          op_i,
    output logic                        ext_req_o,
    output logic [W-1:0]                ext_a_o,
    output logic [W-1:0]                ext_b_o,
    output logic                        ext_op_o,
    input  logic [W-1:0]                ext_result_i,
    input  logic                        ext_done_i,
    input  logic                        ext_invalid_i,
    output logic [W-1:0]                result_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [NUM_REQ-1:0]          invalid_o,
    output logic                        busy_o
);

    localparam int GW   = $clog2(NUM_REQ);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);

    chan_state_t        state_q, state_d;
    logic [GW-1:0]      ptr_q, grant_q, pick_idx;
    logic [W-1:0]       a_q, b_q, res_q, out_q;
    logic               op_q, ext_req_q, rinv_q, timeout;
    logic [WD_W-1:0]    wd_q;
    logic [NUM_REQ-1:0] done_q, inv_q, grant_oh;
    rr_pick_t           pick;

    always_comb pick = rr_pick(MAX_REQ'(req_i), IDX_W'(ptr_q), NUM_REQ);

    assign pick_idx = pick.idx[GW-1:0];
    assign grant_oh = NUM_REQ'(1) << grant_q;
    assign timeout  = (TIMEOUT != 0) && (wd_q == WD_LIM);

    // RELEASE never grants: it is the window in which the owner sees done and drops req.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick.vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ext_done_i || timeout) state_d = RESP;
            RESP:    state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            ext_req_q <= 1'b0;
            wd_q      <= '0;
            res_q     <= '0;
            rinv_q    <= 1'b0;
            out_q     <= '0;
            done_q    <= '0;
            inv_q     <= '0;
        end else begin
            state_q   <= state_d;
            ext_req_q <= (state_q == ISSUE);
            done_q    <= '0;
            inv_q     <= '0;
            out_q     <= '0;
            case (state_q)
                IDLE: if (pick.vld) begin
                    grant_q <= pick_idx;
                    a_q     <= a_i[pick_idx];
                    b_q     <= b_i[pick_idx];
                    op_q    <= op_i[pick_idx];
                end
                ISSUE: wd_q <= '0;
                // A unit done on the timeout cycle takes priority over the abort.
                WAIT: if (ext_done_i) begin
                    res_q  <= ext_result_i;
                    rinv_q <= ext_invalid_i;
                end else if (timeout) begin
                    res_q  <= W'(FP80_ZERO);
                    rinv_q <= 1'b1;
                end else if (wd_q != '1) begin
                    wd_q <= wd_q + 1'b1;
                end
                RESP: begin
                    done_q <= grant_oh;
                    inv_q  <= grant_oh & {NUM_REQ{rinv_q}};
                    out_q  <= res_q;
                    ptr_q  <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ext_req_o = ext_req_q;
    assign ext_a_o   = a_q;
    assign ext_b_o   = b_q;
    assign ext_op_o  = op_q;
    assign result_o  = out_q;
    assign done_o    = done_q;
    assign invalid_o = inv_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: rtl/fpu_arith_arbiter.sv
// Shares one add/sub unit and one mul/div unit among NUM_REQ FPU requesters.
module fpu_arith_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = 80,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   as_req_i,
    input  logic [NUM_REQ*W-1:0] as_a_i,
    input  logic [NUM_REQ*W-1:0] as_b_i,
    input  logic [NUM_REQ-1:0]   as_sub_i,
    output logic [W-1:0]         as_result_o,
    output logic [NUM_REQ-1:0]   as_done_o,
    output logic [NUM_REQ-1:0]   as_invalid_o,
    input  logic [NUM_REQ-1:0]   md_req_i,
    input  logic [NUM_REQ-1:0]   md_op_i,
    input  logic [NUM_REQ*W-1:0] md_a_i,
    input  logic [NUM_REQ*W-1:0] md_b_i,
    output logic [W-1:0]         md_result_o,
    output logic [NUM_REQ-1:0]   md_done_o,
    output logic [NUM_REQ-1:0]   md_invalid_o,
    output logic                 ext_addsub_req_o,
    output logic [W-1:0]         ext_addsub_a_o,
    output logic [W-1:0]         ext_addsub_b_o,
    output logic                 ext_addsub_sub_o,
    input  logic [W-1:0]         ext_addsub_result_i,
    input  logic                 ext_addsub_done_i,
    input  logic                 ext_addsub_invalid_i,
    output logic                 ext_muldiv_req_o,
    output logic                 ext_muldiv_op_o,
    output logic [W-1:0]         ext_muldiv_a_o,
    output logic [W-1:0]         ext_muldiv_b_o,
    input  logic [W-1:0]         ext_muldiv_result_i,
    input  logic                 ext_muldiv_done_i,
    input  logic                 ext_muldiv_invalid_i,
    output logic [1:0]           busy_o
);

    logic as_busy, md_busy;

    fpu_arb_channel #(.NUM_REQ(NUM_REQ), .W(W), .TIMEOUT(TIMEOUT)) u_as (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (as_req_i),
        .a_i          (as_a_i),
        .b_i          (as_b_i),
        .op_i         (as_sub_i),
        .ext_req_o    (ext_addsub_req_o),
        .ext_a_o      (ext_addsub_a_o),
        .ext_b_o      (ext_addsub_b_o),
        .ext_op_o     (ext_addsub_sub_o),
        .ext_result_i (ext_addsub_result_i),
        .ext_done_i   (ext_addsub_done_i),
        .ext_invalid_i(ext_addsub_invalid_i),
        .result_o     (as_result_o),
        .done_o       (as_done_o),
        .invalid_o    (as_invalid_o),
        .busy_o       (as_busy)
    );

    fpu_arb_channel #(.NUM_REQ(NUM_REQ), .W(W), .TIMEOUT(TIMEOUT)) u_md (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (md_req_i),
        .a_i          (md_a_i),
        .b_i          (md_b_i),
        .op_i         (md_op_i),
        .ext_req_o    (ext_muldiv_req_o),
        .ext_a_o      (ext_muldiv_a_o),
        .ext_b_o      (ext_muldiv_b_o),
        .ext_op_o     (ext_muldiv_op_o),
        .ext_result_i (ext_muldiv_result_i),
        .ext_done_i   (ext_muldiv_done_i),
        .ext_invalid_i(ext_muldiv_invalid_i),
        .result_o     (md_result_o),
        .done_o       (md_done_o),
        .invalid_o    (md_invalid_o),
        .busy_o       (md_busy)
    );

    assign busy_o = {md_busy, as_busy};

endmodule

// File: tb/tb_fpu_arith_arbiter.sv
// Directed bench for fpu_arith_arbiter with xor-result unit stubs on both channels.
module tb_fpu_arith_arbiter;
    import fpu_arb_pkg::*;

    localparam int NR = 2;
    localparam int W  = 80;
    localparam int TO = 20;

    logic            clk, rst_n;
    logic [NR-1:0]   as_req, as_sub, md_req, md_op;
    logic [NR*W-1:0] as_a, as_b, md_a, md_b;
    logic [W-1:0]    as_result, md_result;
    logic [NR-1:0]   as_done, as_invalid, md_done, md_invalid;
    logic            ext_addsub_req, ext_addsub_sub, ext_addsub_done;
    logic [W-1:0]    ext_addsub_a, ext_addsub_b, ext_addsub_result;
    logic            ext_muldiv_req, ext_muldiv_op, ext_muldiv_done;
    logic [W-1:0]    ext_muldiv_a, ext_muldiv_b, ext_muldiv_result;
    logic [1:0]      busy;

    logic            as_u_done, as_inj, md_u_done, md_hang;
    logic [W-1:0]    as_res, md_res;
    int              as_cnt, md_cnt, as_viol, md_viol, as_pulses, md_pulses;
    int              as_dcnt [NR];
    int              md_dcnt [NR];
    int              checks, errors;

    assign ext_addsub_done = as_u_done | as_inj;
    assign ext_muldiv_done = md_u_done;

    fpu_arith_arbiter #(.NUM_REQ(NR), .W(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .as_req_i(as_req), .as_a_i(as_a), .as_b_i(as_b), .as_sub_i(as_sub),
        .as_result_o(as_result), .as_done_o(as_done), .as_invalid_o(as_invalid),
        .md_req_i(md_req), .md_op_i(md_op), .md_a_i(md_a), .md_b_i(md_b),
        .md_result_o(md_result), .md_done_o(md_done), .md_invalid_o(md_invalid),
        .ext_addsub_req_o(ext_addsub_req), .ext_addsub_a_o(ext_addsub_a),
        .ext_addsub_b_o(ext_addsub_b), .ext_addsub_sub_o(ext_addsub_sub),
        .ext_addsub_result_i(ext_addsub_result), .ext_addsub_done_i(ext_addsub_done),
        .ext_addsub_invalid_i(1'b0),
        .ext_muldiv_req_o(ext_muldiv_req), .ext_muldiv_op_o(ext_muldiv_op),
        .ext_muldiv_a_o(ext_muldiv_a), .ext_muldiv_b_o(ext_muldiv_b),
        .ext_muldiv_result_i(ext_muldiv_result), .ext_muldiv_done_i(ext_muldiv_done),
        .ext_muldiv_invalid_i(1'b0),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 5-cycle add/sub stub; a start pulse while busy counts as a violation.
    always @(negedge clk) begin
        as_u_done = 1'b0;
        if (!rst_n) as_cnt = 0;
        else begin
            if (as_cnt != 0) begin
                as_cnt--;
                if (as_cnt == 0) begin as_u_done = 1'b1; ext_addsub_result = as_res; end
            end
            if (ext_addsub_req) begin
                if (as_cnt != 0) as_viol++;
                as_cnt = 5;
                as_res = ext_addsub_a ^ ext_addsub_b;
                as_pulses++;
            end
            for (int i = 0; i < NR; i++) if (as_done[i]) as_dcnt[i]++;
        end
    end

    // 8-cycle mul/div stub; md_hang makes it never answer.
    always @(negedge clk) begin
        md_u_done = 1'b0;
        if (!rst_n) md_cnt = 0;
        else begin
            if (md_cnt != 0) begin
                md_cnt--;
                if (md_cnt == 0) begin md_u_done = 1'b1; ext_muldiv_result = md_res; end
            end
            if (ext_muldiv_req) begin
                if (md_cnt != 0) md_viol++;
                md_cnt = md_hang ? 0 : 8;
                md_res = ext_muldiv_a ^ ext_muldiv_b;
                md_pulses++;
            end
            for (int i = 0; i < NR; i++) if (md_done[i]) md_dcnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic as_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input string tag);
        bit seen;
        as_a[r*W +: W] = a;
        as_b[r*W +: W] = b;
        as_sub[r]      = s;
        as_req[r]      = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            if (as_done[r]) seen = 1'b1;
        end
        chk({tag, "_done"}, W'(seen), W'(1));
        if (seen) begin
            chk({tag, "_res"}, as_result, a ^ b);
            chk({tag, "_inv"}, W'(as_invalid), W'(0));
        end
        as_req[r] = 1'b0;
    endtask

    task automatic md_do(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input string tag);
        bit seen;
        md_a[r*W +: W] = a;
        md_b[r*W +: W] = b;
        md_op[r]       = op;
        md_req[r]      = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            if (md_done[r]) seen = 1'b1;
        end
        chk({tag, "_done"}, W'(seen), W'(1));
        if (seen) begin
            chk({tag, "_res"}, md_result, a ^ b);
            chk({tag, "_inv"}, W'(md_invalid), W'(0));
        end
        md_req[r] = 1'b0;
    endtask

    logic [W-1:0] A1, B1, A0x, A1x;
    int base_p, base_d0, base_d1, base_m1, base_m0, k, n;
    bit seen;

    initial begin
        checks = 0; errors = 0;
        as_viol = 0; md_viol = 0; as_pulses = 0; md_pulses = 0;
        as_cnt = 0; md_cnt = 0; as_u_done = 0; md_u_done = 0; as_inj = 0; md_hang = 0;
        as_res = '0; md_res = '0; ext_addsub_result = '0; ext_muldiv_result = '0;
        for (int i = 0; i < NR; i++) begin as_dcnt[i] = 0; md_dcnt[i] = 0; end
        as_req = '0; as_sub = '0; md_req = '0; md_op = '0;
        as_a = '0; as_b = '0; md_a = '0; md_b = '0;
        A1  = 80'h3FFF_8000000000000000;
        B1  = 80'h4000_C000000000000000;
        A0x = 80'h1111_0000000000000000;
        A1x = 80'h2222_0000000000000000;
        rst_n = 1'b0;
        #2;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_as_done", W'(as_done), W'(0));
        chk("rst_md_done", W'(md_done), W'(0));
        chk("rst_ext_req", W'({ext_addsub_req, ext_muldiv_req}), W'(0));
        chk("rst_ext_a", ext_addsub_a, '0);
        chk("rst_md_res", md_result, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: single add/sub from requester 0, latency and routing
        as_a[0 +: W] = A1; as_b[0 +: W] = B1; as_sub[0] = 1'b1; as_req[0] = 1'b1;
        tick();
        chk("t1_req_early", W'(ext_addsub_req), W'(0));
        tick();
        chk("t1_ext_req", W'(ext_addsub_req), W'(1));
        chk("t1_ext_a", ext_addsub_a, A1);
        chk("t1_ext_sub", W'(ext_addsub_sub), W'(1));
        chk("t1_busy", W'(busy), W'(1));
        tick();
        chk("t1_pulse_len", W'(ext_addsub_req), W'(0));
        seen = 0;
        for (n = 0; n < 20 && !seen; n++) begin
            if (ext_addsub_done) seen = 1;
            else tick();
        end
        chk("t1_unit_done", W'(seen), W'(1));
        tick();
        chk("t1_done_early", W'(as_done), W'(0));
        tick();
        chk("t1_done", W'(as_done), W'(2'b01));
        chk("t1_res", as_result, A1 ^ B1);
        chk("t1_inv", W'(as_invalid), W'(0));
        as_req[0] = 1'b0;
        tick();
        chk("t1_done_off", W'(as_done), W'(0));
        chk("t1_idle", W'(busy), W'(0));
        as_op(1, B1, A1x, 1'b0, "t1b");

        // 2: both requesters held, grants alternate starting at 0
        as_a[0 +: W] = A0x; as_a[W +: W] = A1x; as_b = '0; as_req = 2'b11;
        base_p = as_pulses; base_d0 = as_dcnt[0]; base_d1 = as_dcnt[1];
        k = 0;
        for (n = 0; n < 300 && k < 6; n++) begin
            tick();
            if (ext_addsub_req) begin
                chk($sformatf("t2_grant%0d", k), W'(ext_addsub_a == A1x), W'(k % 2));
                k++;
            end
        end
        as_req = '0;
        repeat (20) tick();
        chk("t2_pulses", W'(as_pulses - base_p), W'(6));
        chk("t2_done0", W'(as_dcnt[0] - base_d0), W'(3));
        chk("t2_done1", W'(as_dcnt[1] - base_d1), W'(3));

        // 3: concurrent add/sub (req0) and div (req1)
        base_d1 = as_dcnt[1]; base_m0 = md_dcnt[0];
        fork
            as_op(0, A1, A0x, 1'b0, "t3_as");
            md_do(1, B1, A1x, OP_DIV, "t3_md");
            begin
                tick(); tick();
                chk("t3_busy", W'(busy), W'(2'b11));
                chk("t3_both_req", W'({ext_addsub_req, ext_muldiv_req}), W'(2'b11));
                chk("t3_md_op", W'(ext_muldiv_op), W'(OP_DIV));
            end
        join
        repeat (4) tick();
        chk("t3_as_other", W'(as_dcnt[1] - base_d1), W'(0));
        chk("t3_md_other", W'(md_dcnt[0] - base_m0), W'(0));

        // 4: hung mul/div unit is aborted by the watchdog
        md_hang = 1'b1;
        md_a[0 +: W] = A1; md_b[0 +: W] = B1; md_op[0] = OP_MUL; md_req[0] = 1'b1;
        seen = 0;
        for (n = 0; n < 10 && !seen; n++) begin
            tick();
            if (ext_muldiv_req) seen = 1;
        end
        chk("t4_issue", W'(seen), W'(1));
        seen = 0;
        for (n = 0; n < 40 && !seen; ) begin
            tick(); n++;
            if (md_done[0]) seen = 1;
        end
        chk("t4_lat", W'(n), W'(TO + 2));
        chk("t4_inv", W'(md_invalid), W'(2'b01));
        chk("t4_res", md_result, '0);
        md_req[0] = 1'b0;
        md_hang = 1'b0;
        tick();
        md_do(1, A1x, B1, OP_MUL, "t4_next");

        // 5: reset during WAIT, then stale unit done
        as_a[W +: W] = A1; as_b[W +: W] = B1; as_req[1] = 1'b1;
        seen = 0;
        for (n = 0; n < 10 && !seen; n++) begin
            tick();
            if (ext_addsub_req) seen = 1;
        end
        chk("t5_issue", W'(seen), W'(1));
        tick(); tick();
        rst_n = 1'b0; as_req[1] = 1'b0;
        #1;
        chk("t5_busy", W'(busy), W'(0));
        chk("t5_ext_req", W'(ext_addsub_req), W'(0));
        chk("t5_ext_a", ext_addsub_a, '0);
        chk("t5_outs", W'({as_done, as_invalid, ext_addsub_sub}), W'(0));
        chk("t5_res", as_result, '0);
        tick();
        rst_n = 1'b1;
        base_d0 = as_dcnt[0] + as_dcnt[1];
        tick();
        as_inj = 1'b1;
        tick();
        as_inj = 1'b0;
        repeat (4) tick();
        chk("t5_stale", W'(as_dcnt[0] + as_dcnt[1] - base_d0), W'(0));
        chk("t5_stale_busy", W'(busy), W'(0));
        as_op(0, A0x, B1, 1'b1, "t5_after");

        // 6: requester drops req in the RELEASE cycle, no duplicate grant
        base_p = as_pulses; base_d0 = as_dcnt[0];
        for (int i = 0; i < 3; i++) as_op(0, A1 + W'(i), B1, 1'b0, $sformatf("t6_op%0d", i));
        repeat (10) tick();
        chk("t6_pulses", W'(as_pulses - base_p), W'(3));
        chk("t6_dones", W'(as_dcnt[0] - base_d0), W'(3));
        chk("viol", W'(as_viol + md_viol), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
